fpga_rst_ctrl: RTL and testbench

Board-level reset sequencer feeding the SoC top's active-low reset input, upstream of `retrosoc_asic`.
- Synchronises clock-wizard lock and the raw push-button; debounces the button.
- Holds the SoC in reset until lock is stable plus a fixed stretch.
- Re-enters reset on lock loss, button press or a software request.
- Runs on the clock-wizard output clock.

---
 rtl/fpga_rst_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_fpga_rst_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpga_rst_ctrl.sv
// Board reset sequencer: holds the SoC in reset until PLL lock and button release are stable.
// Latency: SYNC_STAGES+1+HOLD_CYCLES edges from lock/release to soc_rst_n_o rising (67 by default).
// Backpressure: none; free-running control block with no handshake.
//
// Ports:
//   clk_i         clock-wizard output clock
//   rst_n_i       synchronous active-low block reset
//   pll_locked_i  clock-wizard lock (asynchronous)
//   btn_n_i       raw active-low reset button (asynchronous, bouncy)
//   sw_rst_req_i  single-cycle synchronous software reset request
//   soc_rst_n_o   registered active-low reset to the SoC
//   rst_busy_o    high while the sequencer is not in RUN
//   rst_cause_o   last reset cause: 00 power-on, 01 lock loss, 10 button, 11 software
//
// Build option: define RST_CTRL_CAUSE_EN to keep a reset-cause register;
// without it rst_cause_o is tied to 2'b00.

module fpga_rst_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = 16,
  parameter int HOLD_CYCLES = 64,
  parameter int CNT_W       = 16
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       pll_locked_i,
  input  logic       btn_n_i,
  input  logic       sw_rst_req_i,
  output logic       soc_rst_n_o,
  output logic       rst_busy_o,
  output logic [1:0] rst_cause_o
);

  // --------------------------------------------------------------------------
  // Elaboration-time parameter sanity
  // --------------------------------------------------------------------------
  generate
    if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("fpga_rst_ctrl: SYNC_STAGES must be >= 2");
    end
    if (DEB_CYCLES < 2) begin : g_bad_deb
      $error("fpga_rst_ctrl: DEB_CYCLES must be >= 2");
    end
    if (HOLD_CYCLES < 1) begin : g_bad_hold
      $error("fpga_rst_ctrl: HOLD_CYCLES must be >= 1");
    end
    if ((64'(DEB_CYCLES) > (64'd1 << CNT_W)) || (64'(HOLD_CYCLES) > (64'd1 << CNT_W))) begin : g_bad_cnt
      $error("fpga_rst_ctrl: CNT_W too narrow for DEB_CYCLES/HOLD_CYCLES");
    end
  endgenerate

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    HOLD      = 2'd1,
    RUN       = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // Synchronisers
  // --------------------------------------------------------------------------
  // Plain flop chains: nothing combinational in front of the last stage, so
  // metastability only has to resolve through flops. The button chain resets
  // to 1 (released) so a reset does not look like a press.
  logic [SYNC_STAGES-1:0] lock_sync;
  logic [SYNC_STAGES-1:0] btn_sync;
  logic                   locked_s;
  logic                   btn_s;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      lock_sync <= '0;
      btn_sync  <= '1;
    end else begin
      lock_sync <= {lock_sync[SYNC_STAGES-2:0], pll_locked_i};
      btn_sync  <= {btn_sync[SYNC_STAGES-2:0], btn_n_i};
    end
  end

  assign locked_s = lock_sync[SYNC_STAGES-1];
  assign btn_s    = btn_sync[SYNC_STAGES-1];

  // --------------------------------------------------------------------------
  // Button debounce
  // --------------------------------------------------------------------------
  // The debounced level only flips after DEB_CYCLES consecutive cycles of
  // disagreement; any cycle of agreement restarts the count, so bounces
  // shorter than that never reach the state machine.
  logic             btn_deb_q;
  logic [CNT_W-1:0] deb_cnt_q;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      btn_deb_q <= 1'b1;
      deb_cnt_q <= '0;
    end else if (btn_s == btn_deb_q) begin
      deb_cnt_q <= '0;
    end else if (deb_cnt_q == DEB_LAST) begin
      btn_deb_q <= btn_s;
      deb_cnt_q <= '0;
    end else begin
      deb_cnt_q <= deb_cnt_q + CNT_W'(1);
    end
  end

  // --------------------------------------------------------------------------
  // Sequencer state machine
  // --------------------------------------------------------------------------
  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] hold_cnt_q;
  logic [CNT_W-1:0] hold_cnt_d;
  logic             soc_rst_n_q;
  logic             soc_rst_n_d;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q     <= WAIT_LOCK;
      hold_cnt_q  <= '0;
      soc_rst_n_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      soc_rst_n_q <= soc_rst_n_d;
    end
  end

  // soc_rst_n_d is decided together with the state so the output flop changes
  // on exactly the same edge as the state register.
  always_comb begin
    state_d     = state_q;
    hold_cnt_d  = hold_cnt_q;
    soc_rst_n_d = soc_rst_n_q;
    case (state_q)
      WAIT_LOCK: begin
        if (locked_s && btn_deb_q) begin
          state_d    = HOLD;
          hold_cnt_d = '0;
        end
      end
      HOLD: begin
        if (!locked_s || !btn_deb_q) begin
          state_d    = WAIT_LOCK;
          hold_cnt_d = '0;
        end else if (hold_cnt_q == HOLD_LAST) begin
          state_d     = RUN;
          soc_rst_n_d = 1'b1;
        end else begin
          hold_cnt_d = hold_cnt_q + CNT_W'(1);
        end
      end
      RUN: begin
        // Software requests only matter here; in the other states the SoC
        // is already held in reset.
        if (!locked_s || !btn_deb_q || sw_rst_req_i) begin
          state_d     = WAIT_LOCK;
          soc_rst_n_d = 1'b0;
        end
      end
      default: begin
        state_d     = WAIT_LOCK;
        hold_cnt_d  = '0;
        soc_rst_n_d = 1'b0;
      end
    endcase
  end

  assign soc_rst_n_o = soc_rst_n_q;
  assign rst_busy_o  = (state_q != RUN);

  // --------------------------------------------------------------------------
  // Reset cause
  // --------------------------------------------------------------------------
`ifdef RST_CTRL_CAUSE_EN
  logic [1:0] cause_q;
  logic [1:0] cause_d;

  // Captured only when RUN is left; aborting HOLD back to WAIT_LOCK keeps the
  // cause of the RUN exit that started the sequence. Priority mirrors the
  // severity of the event: lock loss, then button, then software.
  always_comb begin
    cause_d = cause_q;
    if (state_q == RUN && state_d == WAIT_LOCK) begin
      if (!locked_s) begin
        cause_d = 2'b01;
      end else if (!btn_deb_q) begin
        cause_d = 2'b10;
      end else begin
        cause_d = 2'b11;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      cause_q <= 2'b00;
    end else begin
      cause_q <= cause_d;
    end
  end

  assign rst_cause_o = cause_q;
`else
  assign rst_cause_o = 2'b00;
`endif

endmodule

// File: tb/tb_fpga_rst_ctrl.sv
module tb_fpga_rst_ctrl;

  logic       clk = 1'b0;
  logic       rst_n_i;
  logic       pll_locked_i;
  logic       btn_n_i;
  logic       sw_rst_req_i;
  logic       soc_rst_n_o;
  logic       rst_busy_o;
  logic [1:0] rst_cause_o;

`ifdef RST_CTRL_CAUSE_EN
  localparam logic [1:0] C_LOCK = 2'b01;
  localparam logic [1:0] C_BTN  = 2'b10;
  localparam logic [1:0] C_SW   = 2'b11;
`else
  localparam logic [1:0] C_LOCK = 2'b00;
  localparam logic [1:0] C_BTN  = 2'b00;
  localparam logic [1:0] C_SW   = 2'b00;
`endif

  fpga_rst_ctrl #(
    .SYNC_STAGES(2),
    .DEB_CYCLES (16),
    .HOLD_CYCLES(64),
    .CNT_W      (16)
  ) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n_i),
    .pll_locked_i(pll_locked_i),
    .btn_n_i     (btn_n_i),
    .sw_rst_req_i(sw_rst_req_i),
    .soc_rst_n_o (soc_rst_n_o),
    .rst_busy_o  (rst_busy_o),
    .rst_cause_o (rst_cause_o)
  );

  always #5 clk = ~clk;

  // Edge counter: after rising edge n (and from then until the next edge) cyc == n.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int   cyc;
    logic val;
  } ev_t;

  ev_t exp_q[$];
  ev_t obs_q[$];

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  // Monitor: records every change of soc_rst_n_o with the edge it happened on.
  bit   mon_en = 1'b0;
  logic prev_soc;
  always @(posedge clk) begin
    ev_t o;
    #2;
    if (mon_en && (soc_rst_n_o !== prev_soc)) begin
      o.cyc = cyc;
      o.val = soc_rst_n_o;
      obs_q.push_back(o);
    end
    prev_soc = soc_rst_n_o;
  end

  task automatic push_exp(input int at, input logic v);
    ev_t e;
    e.cyc = at;
    e.val = v;
    exp_q.push_back(e);
  endtask

  // Waits (bounded) for the monitor to have an observation; does not compare.
  task automatic wait_obs(input int budget, output bit got);
    for (int i = 0; i < budget && obs_q.size() == 0; i++) @(negedge clk);
    got = (obs_q.size() != 0);
  endtask

  task automatic test_reset;
    ev_t e, o;
    bit  got;
    int  t0;
    rst_n_i = 1'b0; pll_locked_i = 1'b1; btn_n_i = 1'b1; sw_rst_req_i = 1'b0;
    repeat (3) @(negedge clk);
    n_chk++; if (soc_rst_n_o !== 1'b0) begin n_fail++; $display("FAIL reset_soc: got %b want 0", soc_rst_n_o); end else n_pass++;
    n_chk++; if (rst_busy_o !== 1'b1) begin n_fail++; $display("FAIL reset_busy: got %b want 1", rst_busy_o); end else n_pass++;
    n_chk++; if (rst_cause_o !== 2'b00) begin n_fail++; $display("FAIL reset_cause: got %b want 00", rst_cause_o); end else n_pass++;
    mon_en  = 1'b1;
    rst_n_i = 1'b1;
    t0 = cyc;
    push_exp(t0 + 67, 1'b1);
    repeat (66) @(negedge clk);
    n_chk++; if (soc_rst_n_o !== 1'b0) begin n_fail++; $display("FAIL reset_soc_edge66: got %b want 0", soc_rst_n_o); end else n_pass++;
    n_chk++; if (rst_busy_o !== 1'b1) begin n_fail++; $display("FAIL reset_busy_edge66: got %b want 1", rst_busy_o); end else n_pass++;
    while (exp_q.size() > 0) begin
      wait_obs(300, got);
      e = exp_q.pop_front();
      n_chk++;
      if (!got) begin n_fail++; $display("FAIL reset_seq: no soc_rst_n_o change, want %b at edge %0d", e.val, e.cyc); end
      else begin
        o = obs_q.pop_front();
        if (o.cyc !== e.cyc || o.val !== e.val) begin n_fail++; $display("FAIL reset_seq: got %b at edge %0d want %b at edge %0d", o.val, o.cyc, e.val, e.cyc); end
        else n_pass++;
      end
    end
    n_chk++; if (rst_busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy_run: got %b want 0", rst_busy_o); end else n_pass++;
  endtask

  task automatic test_lock_late;
    ev_t e, o;
    bit  got;
    int  t0;
    pll_locked_i = 1'b0;
    rst_n_i = 1'b0;
    t0 = cyc;
    push_exp(t0 + 1, 1'b0);
    repeat (2) @(negedge clk);
    rst_n_i = 1'b1;
    repeat (500) @(negedge clk);
    n_chk++; if (soc_rst_n_o !== 1'b0 || rst_busy_o !== 1'b1) begin n_fail++; $display("FAIL nolock_hold: got soc=%b busy=%b want soc=0 busy=1", soc_rst_n_o, rst_busy_o); end else n_pass++;
    pll_locked_i = 1'b1;
    t0 = cyc;
    push_exp(t0 + 67, 1'b1);
    while (exp_q.size() > 0) begin
      wait_obs(300, got);
      e = exp_q.pop_front();
      n_chk++;
      if (!got) begin n_fail++; $display("FAIL lock_late_seq: no soc_rst_n_o change, want %b at edge %0d", e.val, e.cyc); end
      else begin
        o = obs_q.pop_front();
        if (o.cyc !== e.cyc || o.val !== e.val) begin n_fail++; $display("FAIL lock_late_seq: got %b at edge %0d want %b at edge %0d", o.val, o.cyc, e.val, e.cyc); end
        else n_pass++;
      end
    end
  endtask

  task automatic test_btn;
    ev_t e, o;
    bit  got;
    int  t0;
    btn_n_i = 1'b0;
    repeat (10) @(negedge clk);
    btn_n_i = 1'b1;
    repeat (30) @(negedge clk);
    n_chk++; if (obs_q.size() != 0 || soc_rst_n_o !== 1'b1) begin n_fail++; $display("FAIL btn_glitch: got soc=%b changes=%0d want soc=1 changes=0", soc_rst_n_o, obs_q.size()); end else n_pass++;
    btn_n_i = 1'b0;
    t0 = cyc;
    push_exp(t0 + 19, 1'b0);
    repeat (40) @(negedge clk);
    n_chk++; if (rst_cause_o !== C_BTN) begin n_fail++; $display("FAIL btn_cause: got %b want %b", rst_cause_o, C_BTN); end else n_pass++;
    n_chk++; if (rst_busy_o !== 1'b1) begin n_fail++; $display("FAIL btn_busy: got %b want 1", rst_busy_o); end else n_pass++;
    btn_n_i = 1'b1;
    t0 = cyc;
    // release: 2 sync + 16 debounce + 1 WAIT_LOCK + 64 HOLD
    push_exp(t0 + 83, 1'b1);
    while (exp_q.size() > 0) begin
      wait_obs(300, got);
      e = exp_q.pop_front();
      n_chk++;
      if (!got) begin n_fail++; $display("FAIL btn_seq: no soc_rst_n_o change, want %b at edge %0d", e.val, e.cyc); end
      else begin
        o = obs_q.pop_front();
        if (o.cyc !== e.cyc || o.val !== e.val) begin n_fail++; $display("FAIL btn_seq: got %b at edge %0d want %b at edge %0d", o.val, o.cyc, e.val, e.cyc); end
        else n_pass++;
      end
    end
  endtask

  task automatic test_sw;
    ev_t e, o;
    bit  got;
    int  t0;
    sw_rst_req_i = 1'b1;
    t0 = cyc;
    push_exp(t0 + 1, 1'b0);
    push_exp(t0 + 66, 1'b1);
    @(negedge clk);
    sw_rst_req_i = 1'b0;
    n_chk++; if (soc_rst_n_o !== 1'b0 || rst_busy_o !== 1'b1) begin n_fail++; $display("FAIL sw_assert: got soc=%b busy=%b want soc=0 busy=1", soc_rst_n_o, rst_busy_o); end else n_pass++;
    n_chk++; if (rst_cause_o !== C_SW) begin n_fail++; $display("FAIL sw_cause: got %b want %b", rst_cause_o, C_SW); end else n_pass++;
    while (exp_q.size() > 0) begin
      wait_obs(300, got);
      e = exp_q.pop_front();
      n_chk++;
      if (!got) begin n_fail++; $display("FAIL sw_seq: no soc_rst_n_o change, want %b at edge %0d", e.val, e.cyc); end
      else begin
        o = obs_q.pop_front();
        if (o.cyc !== e.cyc || o.val !== e.val) begin n_fail++; $display("FAIL sw_seq: got %b at edge %0d want %b at edge %0d", o.val, o.cyc, e.val, e.cyc); end
        else n_pass++;
      end
    end
  endtask

  task automatic test_hold_lock_loss;
    ev_t e, o;
    bit  got;
    int  t0;
    // software request: WAIT_LOCK after edge t0+1, HOLD from edge t0+2
    sw_rst_req_i = 1'b1;
    t0 = cyc;
    push_exp(t0 + 1, 1'b0);
    @(negedge clk);
    sw_rst_req_i = 1'b0;
    repeat (31) @(negedge clk);
    pll_locked_i = 1'b0;
    repeat (5) @(negedge clk);
    n_chk++; if (soc_rst_n_o !== 1'b0 || rst_busy_o !== 1'b1) begin n_fail++; $display("FAIL hold_abort: got soc=%b busy=%b want soc=0 busy=1", soc_rst_n_o, rst_busy_o); end else n_pass++;
    pll_locked_i = 1'b1;
    t0 = cyc;
    push_exp(t0 + 67, 1'b1);
    while (exp_q.size() > 0) begin
      wait_obs(300, got);
      e = exp_q.pop_front();
      n_chk++;
      if (!got) begin n_fail++; $display("FAIL hold_abort_seq: no soc_rst_n_o change, want %b at edge %0d", e.val, e.cyc); end
      else begin
        o = obs_q.pop_front();
        if (o.cyc !== e.cyc || o.val !== e.val) begin n_fail++; $display("FAIL hold_abort_seq: got %b at edge %0d want %b at edge %0d", o.val, o.cyc, e.val, e.cyc); end
        else n_pass++;
      end
    end
    n_chk++; if (rst_cause_o !== C_SW) begin n_fail++; $display("FAIL hold_abort_cause: got %b want %b", rst_cause_o, C_SW); end else n_pass++;
  endtask

  task automatic test_coincident;
    ev_t e, o;
    bit  got;
    int  t0;
    // lock drop becomes visible at locked_s for edge t0+3; software request lands on that same edge
    pll_locked_i = 1'b0;
    t0 = cyc;
    push_exp(t0 + 3, 1'b0);
    repeat (2) @(negedge clk);
    sw_rst_req_i = 1'b1;
    @(negedge clk);
    sw_rst_req_i = 1'b0;
    n_chk++; if (rst_cause_o !== C_LOCK) begin n_fail++; $display("FAIL coincident_cause: got %b want %b", rst_cause_o, C_LOCK); end else n_pass++;
    repeat (3) @(negedge clk);
    pll_locked_i = 1'b1;
    t0 = cyc;
    push_exp(t0 + 67, 1'b1);
    while (exp_q.size() > 0) begin
      wait_obs(300, got);
      e = exp_q.pop_front();
      n_chk++;
      if (!got) begin n_fail++; $display("FAIL coincident_seq: no soc_rst_n_o change, want %b at edge %0d", e.val, e.cyc); end
      else begin
        o = obs_q.pop_front();
        if (o.cyc !== e.cyc || o.val !== e.val) begin n_fail++; $display("FAIL coincident_seq: got %b at edge %0d want %b at edge %0d", o.val, o.cyc, e.val, e.cyc); end
        else n_pass++;
      end
    end
  endtask

  task automatic test_rst_mid;
    ev_t e, o;
    bit  got;
    int  t0;
    rst_n_i = 1'b0;
    t0 = cyc;
    push_exp(t0 + 1, 1'b0);
    @(negedge clk);
    rst_n_i = 1'b1;
    n_chk++; if (soc_rst_n_o !== 1'b0 || rst_busy_o !== 1'b1) begin n_fail++; $display("FAIL mid_reset: got soc=%b busy=%b want soc=0 busy=1", soc_rst_n_o, rst_busy_o); end else n_pass++;
    n_chk++; if (rst_cause_o !== 2'b00) begin n_fail++; $display("FAIL mid_reset_cause: got %b want 00", rst_cause_o); end else n_pass++;
    t0 = cyc;
    push_exp(t0 + 67, 1'b1);
    while (exp_q.size() > 0) begin
      wait_obs(300, got);
      e = exp_q.pop_front();
      n_chk++;
      if (!got) begin n_fail++; $display("FAIL mid_reset_seq: no soc_rst_n_o change, want %b at edge %0d", e.val, e.cyc); end
      else begin
        o = obs_q.pop_front();
        if (o.cyc !== e.cyc || o.val !== e.val) begin n_fail++; $display("FAIL mid_reset_seq: got %b at edge %0d want %b at edge %0d", o.val, o.cyc, e.val, e.cyc); end
        else n_pass++;
      end
    end
  endtask

  initial begin
    rst_n_i = 1'b0; pll_locked_i = 1'b1; btn_n_i = 1'b1; sw_rst_req_i = 1'b0;
    test_reset;
    test_lock_late;
    test_btn;
    test_sw;
    test_hold_lock_loss;
    test_coincident;
    test_rst_mid;
    repeat (20) @(negedge clk);
    n_chk++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL spurious_changes: got %0d extra soc_rst_n_o changes want 0", obs_q.size()); end else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1, "watchdog");
  end

endmodule
